// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: in-flight stage record,
// forwarding-select encoding and the XZR index.
package pipe_pkg;

  localparam int          RD_W         = 5;
  localparam logic [4:0]  ZERO_REG_IDX = 5'd31;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            reg_write;
    logic            is_load;
    logic            sets_flags;
  } stage_rec_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  // A stage only produces a forwardable value if it really writes a non-XZR register.
  function automatic logic is_writer(stage_rec_t rec, logic [RD_W-1:0] zero_idx);
    return rec.valid & rec.reg_write & (rec.rd != zero_idx);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Priority forwarding match for one ALU operand: EX over MEM over WB over regfile.
module fwd_select
  import pipe_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31
) (
  input  logic             use_src,
  input  logic [REG_W-1:0] src,
  input  logic             ex_writer,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_writer,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             wb_writer,
  input  logic [REG_W-1:0] wb_rd,
  output logic [1:0]       sel
);

  localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

  fwd_sel_e sel_e;

  always_comb begin
    sel_e = FWD_RF;
    if (use_src && (src != ZERO_IDX)) begin
      // A load still in EX has no data yet; the stall covers this cycle.
      if (ex_writer && (src == ex_rd)) begin
        sel_e = ex_is_load ? FWD_RF : FWD_EX;
      end else if (mem_writer && (src == mem_rd)) begin
        sel_e = FWD_MEM;
      end else if (wb_writer && (src == wb_rd)) begin
        sel_e = FWD_WB;
      end
    end
  end

  assign sel = sel_e;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: tracks EX/MEM/WB destinations and
// flag producers, drives stall/bubble/flush, forwarding selects and perf counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = int'(ZERO_REG_IDX),
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_ra,
  input  logic [REG_W-1:0] id_rb,
  input  logic             id_use_ra,
  input  logic             id_use_rb,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic             id_sets_flags,
  input  logic             id_uses_flags,
  input  logic             id_br_taken,
  output logic             stall,
  output logic             bubble,
  output logic             flush_ifid,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

  stage_rec_t       ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             ex_writer, mem_writer, wb_writer;
  logic             load_use, flag_haz, stall_int, flush_int;

  always_comb begin
    ex_writer  = is_writer(ex_q, ZERO_IDX);
    mem_writer = is_writer(mem_q, ZERO_IDX);
    wb_writer  = is_writer(wb_q, ZERO_IDX);
    load_use   = id_valid & ex_writer & ex_q.is_load &
                 ((id_use_ra & (id_ra == ex_q.rd)) | (id_use_rb & (id_rb == ex_q.rd)));
    // Flags settle at the end of EX, so a B.cond right behind a flag setter waits a cycle.
    flag_haz   = id_valid & id_uses_flags & ex_q.valid & ex_q.sets_flags;
    stall_int  = load_use | flag_haz;
    flush_int  = id_valid & id_br_taken & ~stall_int;
  end

  always_comb begin
    wb_d  = mem_q;
    mem_d = ex_q;
    ex_d  = '0;
    if (id_valid && !stall_int) begin
      ex_d.valid      = 1'b1;
      ex_d.rd         = id_rd;
      ex_d.reg_write  = id_reg_write;
      ex_d.is_load    = id_is_load;
      ex_d.sets_flags = id_sets_flags;
    end
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_int && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_int && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  logic [REG_W-1:0] op_src [2];
  logic             op_use [2];
  logic [1:0]       op_sel [2];

  assign op_src[0] = id_ra;
  assign op_src[1] = id_rb;
  assign op_use[0] = id_use_ra;
  assign op_use[1] = id_use_rb;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_select #(
        .REG_W    (REG_W),
        .ZERO_REG (ZERO_REG)
      ) u_fwd (
        .use_src    (op_use[gi]),
        .src        (op_src[gi]),
        .ex_writer  (ex_writer),
        .ex_is_load (ex_q.is_load),
        .ex_rd      (ex_q.rd),
        .mem_writer (mem_writer),
        .mem_rd     (mem_q.rd),
        .wb_writer  (wb_writer),
        .wb_rd      (wb_q.rd),
        .sel        (op_sel[gi])
      );
    end
  endgenerate

  // Load/flag bits past EX only travel along for debug visibility.
  logic unused_fields;
  assign unused_fields = ^{mem_q.is_load, mem_q.sets_flags, wb_q.is_load, wb_q.sets_flags};

  assign stall      = stall_int;
  assign bubble     = stall_int;
  assign flush_ifid = flush_int;
  assign fwd_a_sel  = op_sel[0];
  assign fwd_b_sel  = op_sel[1];
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, randomized run against an
// instruction-queue reference model, and counter saturation on a narrow-counter instance.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        id_valid, id_use_ra, id_use_rb, id_reg_write, id_is_load;
  logic        id_sets_flags, id_uses_flags, id_br_taken;
  logic [4:0]  id_ra, id_rb, id_rd;
  logic        stall, bubble, flush_ifid;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_stall, s_bubble, s_flush;
  logic [1:0]  s_fa, s_fb;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_use_ra(id_use_ra), .id_use_rb(id_use_rb), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_sets_flags(id_sets_flags),
    .id_uses_flags(id_uses_flags), .id_br_taken(id_br_taken),
    .stall(stall), .bubble(bubble), .flush_ifid(flush_ifid),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_use_ra(id_use_ra), .id_use_rb(id_use_rb), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_sets_flags(id_sets_flags),
    .id_uses_flags(id_uses_flags), .id_br_taken(id_br_taken),
    .stall(s_stall), .bubble(s_bubble), .flush_ifid(s_flush),
    .fwd_a_sel(s_fa), .fwd_b_sel(s_fb),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  typedef struct {
    logic       rst, chk, v;
    logic [4:0] ra, rb;
    logic       ua, ub;
    logic [4:0] rd;
    logic       rw, ld, sf, uf, bt;
    logic       e_stall, e_flush;
    logic [1:0] e_fa, e_fb;
    logic [15:0] e_sc, e_fc;
  } vec_t;

  // Reference model: the three oldest in-flight instructions, index 0 = EX.
  typedef struct {
    bit       valid;
    bit [4:0] rd;
    bit       rw, ld, sf;
  } inst_t;

  inst_t       pm [3];
  int unsigned n_stall, n_flush;
  bit          model_ok;
  int          checks, errors, cyc;
  vec_t        vecs [21];

  function automatic vec_t mk(int rst, int chk, int v, int ra, int rb, int ua, int ub,
                              int rd, int rw, int ld, int sf, int uf, int bt,
                              int es, int ef, int efa, int efb, int esc, int efc);
    vec_t r;
    r.rst = 1'(rst); r.chk = 1'(chk); r.v = 1'(v);
    r.ra = 5'(ra); r.rb = 5'(rb); r.ua = 1'(ua); r.ub = 1'(ub); r.rd = 5'(rd);
    r.rw = 1'(rw); r.ld = 1'(ld); r.sf = 1'(sf); r.uf = 1'(uf); r.bt = 1'(bt);
    r.e_stall = 1'(es); r.e_flush = 1'(ef); r.e_fa = 2'(efa); r.e_fb = 2'(efb);
    r.e_sc = 16'(esc); r.e_fc = 16'(efc);
    return r;
  endfunction

  function automatic bit m_writer(inst_t r);
    return r.valid && r.rw && (r.rd != 5'd31);
  endfunction

  function automatic logic [1:0] m_fwd(bit use_s, logic [4:0] src);
    if (!use_s || src == 5'd31) return 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (m_writer(pm[i]) && pm[i].rd == src) return (i == 0 && pm[0].ld) ? 2'd0 : 2'(i + 1);
    end
    return 2'd0;
  endfunction

  function automatic int unsigned sat(int unsigned n, int unsigned mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input bit use_tbl);
    bit         e_lu, e_fh, e_st, e_fl;
    logic [1:0] e_fa, e_fb;
    inst_t      nw;
    reset = v.rst; id_valid = v.v; id_ra = v.ra; id_rb = v.rb;
    id_use_ra = v.ua; id_use_rb = v.ub; id_rd = v.rd; id_reg_write = v.rw;
    id_is_load = v.ld; id_sets_flags = v.sf; id_uses_flags = v.uf; id_br_taken = v.bt;
    @(negedge clk);
    e_lu = v.v && m_writer(pm[0]) && pm[0].ld &&
           ((v.ua && v.ra == pm[0].rd) || (v.ub && v.rb == pm[0].rd));
    e_fh = v.v && v.uf && pm[0].valid && pm[0].sf;
    e_st = e_lu || e_fh;
    e_fl = v.v && v.bt && !e_st;
    e_fa = m_fwd(v.ua, v.ra);
    e_fb = m_fwd(v.ub, v.rb);
    if (model_ok) begin
      check("stall",      32'(stall),       32'(e_st));
      check("bubble",     32'(bubble),      32'(e_st));
      check("flush_ifid", 32'(flush_ifid),  32'(e_fl));
      check("fwd_a_sel",  32'(fwd_a_sel),   32'(e_fa));
      check("fwd_b_sel",  32'(fwd_b_sel),   32'(e_fb));
      check("stall_cnt",  32'(stall_cnt),   sat(n_stall, 16'hFFFF));
      check("flush_cnt",  32'(flush_cnt),   sat(n_flush, 16'hFFFF));
      check("sat_stall_cnt", 32'(s_stall_cnt), sat(n_stall, 15));
      check("sat_flush_cnt", 32'(s_flush_cnt), sat(n_flush, 15));
    end
    if (use_tbl && v.chk) begin
      check("tbl_stall",  32'(stall),      32'(v.e_stall));
      check("tbl_bubble", 32'(bubble),     32'(v.e_stall));
      check("tbl_flush",  32'(flush_ifid), 32'(v.e_flush));
      check("tbl_fwd_a",  32'(fwd_a_sel),  32'(v.e_fa));
      check("tbl_fwd_b",  32'(fwd_b_sel),  32'(v.e_fb));
      check("tbl_stall_cnt", 32'(stall_cnt), 32'(v.e_sc));
      check("tbl_flush_cnt", 32'(flush_cnt), 32'(v.e_fc));
    end
    @(posedge clk);
    if (v.rst) begin
      for (int i = 0; i < 3; i++) pm[i] = '{default: 0};
      n_stall = 0; n_flush = 0; model_ok = 1'b1;
    end else begin
      n_stall += e_st ? 1 : 0;
      n_flush += e_fl ? 1 : 0;
      pm[2] = pm[1]; pm[1] = pm[0];
      nw = '{default: 0};
      if (v.v && !e_st) begin
        nw.valid = 1'b1; nw.rd = v.rd; nw.rw = v.rw; nw.ld = v.ld; nw.sf = v.sf;
      end
      pm[0] = nw;
    end
    cyc++;
    #1;
  endtask

  function automatic logic [4:0] rnd_reg();
    int r;
    r = $urandom_range(0, 7);
    return (r == 7) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    vec_t rv;
    checks = 0; errors = 0; cyc = 0; model_ok = 1'b0; n_stall = 0; n_flush = 0;
    for (int i = 0; i < 3; i++) pm[i] = '{default: 0};
    //            rst chk v  ra rb ua ub rd rw ld sf uf bt  st fl fa fb sc fc
    vecs[0]  = mk(1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 1,  2, 3, 1, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 1,  1, 3, 1, 1, 2, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
    vecs[4]  = mk(0, 1, 1,  1, 9, 1, 1, 7, 1, 0, 0, 0, 0,  0, 0, 2, 0, 0, 0);
    vecs[5]  = mk(0, 1, 1,  8, 0, 1, 0, 4, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 1, 1,  4, 6, 1, 1, 5, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 1,  4, 6, 1, 1, 5, 1, 0, 0, 0, 0,  0, 0, 2, 0, 1, 0);
    vecs[8]  = mk(0, 1, 1, 11,12, 1, 1,10, 1, 0, 1, 0, 0,  0, 0, 0, 0, 1, 0);
    vecs[9]  = mk(0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 1, 0);
    vecs[10] = mk(0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 1, 0, 0, 2, 0);
    vecs[11] = mk(0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 1);
    vecs[12] = mk(0, 1, 1,  2, 3, 1, 1,31, 1, 0, 0, 0, 0,  0, 0, 0, 0, 2, 1);
    vecs[13] = mk(0, 1, 1, 31,31, 1, 1, 9, 1, 0, 0, 0, 0,  0, 0, 0, 0, 2, 1);
    vecs[14] = mk(0, 1, 1,  8, 0, 1, 0, 4, 1, 1, 0, 0, 0,  0, 0, 0, 0, 2, 1);
    vecs[15] = mk(0, 1, 1,  4, 0, 1, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 2, 1);
    vecs[16] = mk(0, 1, 1,  4, 0, 1, 0, 0, 0, 0, 0, 0, 1,  0, 1, 2, 0, 3, 1);
    vecs[17] = mk(0, 1, 1,  8, 0, 1, 0, 4, 1, 1, 0, 0, 0,  0, 0, 0, 0, 3, 2);
    vecs[18] = mk(1, 1, 1,  4, 6, 1, 1, 5, 1, 0, 0, 0, 0,  1, 0, 0, 0, 3, 2);
    vecs[19] = mk(0, 1, 1,  4, 6, 1, 1, 5, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[20] = mk(0, 1, 1,  5, 5, 1, 1, 7, 1, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0);

    reset = 1'b1; id_valid = 1'b0; id_ra = '0; id_rb = '0; id_use_ra = 1'b0;
    id_use_rb = 1'b0; id_rd = '0; id_reg_write = 1'b0; id_is_load = 1'b0;
    id_sets_flags = 1'b0; id_uses_flags = 1'b0; id_br_taken = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 21; i++) step(vecs[i], 1'b1);
    $display("directed table done: checks=%0d errors=%0d", checks, errors);

    for (int i = 0; i < 3000; i++) begin
      rv = mk(($urandom_range(0, 99) == 0) ? 1 : 0, 0, int'($urandom_range(0, 3) != 0),
              int'(rnd_reg()), int'(rnd_reg()), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
              int'(rnd_reg()), int'($urandom_range(0, 1)), int'($urandom_range(0, 2) == 0),
              int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 3) == 0),
              int'($urandom_range(0, 3) == 0), 0, 0, 0, 0, 0, 0);
      step(rv, 1'b0);
    end
    $display("random run done: checks=%0d errors=%0d", checks, errors);

    // Load / dependent taken branch / re-evaluated branch: one stall and one flush per round.
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    for (int i = 0; i < 30; i++) begin
      step(mk(0, 0, 1, 8, 0, 1, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      step(mk(0, 0, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0);
      step(mk(0, 0, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0);
    end
    @(negedge clk);
    check("sat_hold_stall", 32'(s_stall_cnt), 32'h0000000F);
    check("sat_hold_flush", 32'(s_flush_cnt), 32'h0000000F);
    check("wide_stall_30",  32'(stall_cnt),   32'd30);
    check("wide_flush_30",  32'(flush_cnt),   32'd30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
